// File: rtl/ber_delay_checker_pkg.sv
// Shared types and helpers for the PRBS BER delay checker.
package ber_chk_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int SWEEP_W = 8;
    localparam int SAT_W   = 64;

    // Adds inc to a, holding at the all-ones value of a w-bit counter.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic             inc,
                                                 input int unsigned      w);
        logic [SAT_W-1:0] max_v;
        if (w >= SAT_W) begin
            max_v = {SAT_W{1'b1}};
        end else begin
            max_v = (64'd1 << w) - 64'd1;
        end
        if (inc && (a != max_v)) begin
            return a + 64'd1;
        end else begin
            return a;
        end
    endfunction

endpackage

// File: rtl/ber_delay_checker_win_cnt.sv
// WIN_LEN-sample window error counter; total includes the current sample's error.
module ber_win_cnt #(
    parameter int WIN_LEN = 511,
    parameter int WW      = $clog2(WIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic          err,
    output logic          last,
    output logic [WW-1:0] total
);

    logic [WW-1:0] idx_r;
    logic [WW-1:0] sum_r;

    assign last  = inc && (idx_r == WW'(WIN_LEN - 1));
    assign total = sum_r + WW'(err);

    // Sample index and error sum; both restart after the last sample of a window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
            sum_r <= '0;
        end else if (clr) begin
            idx_r <= '0;
            sum_r <= '0;
        end else if (inc) begin
            if (last) begin
                idx_r <= '0;
                sum_r <= '0;
            end else begin
                idx_r <= idx_r + WW'(1);
                sum_r <= total;
            end
        end else begin
            idx_r <= idx_r;
            sum_r <= sum_r;
        end
    end

endmodule

// File: rtl/ber_delay_checker.sv
// PRBS BER checker: sweeps reference delays, locks on the best tap, then counts bits/errors.
// Optional loss-of-lock monitor enabled by defining BER_CHK_RELOCK_EN.
module ber_delay_checker
    import ber_chk_pkg::*;
#(
    parameter  int DEPTH      = 1024,
    parameter  int WIN_LEN    = 511,
    parameter  int LOCK_THR   = 0,
    parameter  int RELOCK_THR = 64,
    parameter  int CNT_W      = 64,
    localparam int DW         = $clog2(DEPTH),
    localparam int WW         = $clog2(WIN_LEN + 1)
) (
    input  logic               clock,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic               i_rx,
    input  logic               i_prbs,
    input  logic               i_clear,
    output logic               o_err,
    output logic               o_locked,
    output logic [DW-1:0]      o_delay,
    output logic [WW-1:0]      o_best_err,
    output logic [CNT_W-1:0]   o_bit_cnt,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [SWEEP_W-1:0] o_sweeps,
    output logic               o_lol
);

    localparam int FW = $clog2(DEPTH + 1);
`ifdef BER_CHK_RELOCK_EN
    localparam bit RELOCK_ON = 1'b1;
`else
    localparam bit RELOCK_ON = 1'b0;
`endif

    state_t          state_r, state_s;
    logic [DEPTH-1:0] sr_r;
    logic [DW-1:0]   tap_r, best_tap_r, best_tap_next_s, tap_s;
    logic [FW-1:0]   fill_r;
    logic [WW-1:0]   best_r, best_next_s, win_total_s;
    logic            sample_s, e_s, win_inc_s, win_last_s, win_clr_s, cnt_en_s;
    logic            fill_done_s, sweep_end_s, lock_ok_s, lol_s, better_s;

    assign sample_s        = i_valid & i_enable;
    assign e_s             = i_rx ^ sr_r[tap_s];
    assign fill_done_s     = sample_s && (state_r == FILL) && (fill_r == FW'(DEPTH - 1));
    assign better_s        = win_total_s < best_r;
    assign best_next_s     = better_s ? win_total_s : best_r;
    assign best_tap_next_s = better_s ? tap_r : best_tap_r;
    assign sweep_end_s     = (state_r == SEARCH) && win_last_s && (tap_r == DW'(DEPTH - 1));
    assign lock_ok_s       = 32'(best_next_s) <= 32'(LOCK_THR);
    assign lol_s           = RELOCK_ON && (state_r == LOCKED) && win_last_s &&
                             (32'(win_total_s) > 32'(RELOCK_THR));

    ber_win_cnt #(.WIN_LEN(WIN_LEN), .WW(WW)) u_win (
        .clk   (clock),
        .rst_n (i_reset_n),
        .clr   (win_clr_s),
        .inc   (win_inc_s),
        .err   (e_s),
        .last  (win_last_s),
        .total (win_total_s)
    );

    // State register.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL:    if (fill_done_s) state_s = SEARCH; else state_s = FILL;
            SEARCH:  if (sweep_end_s && lock_ok_s) state_s = LOCKED; else state_s = SEARCH;
            LOCKED:  if (lol_s) state_s = FILL; else state_s = LOCKED;
            default: state_s = FILL;
        endcase
    end

    // State-dependent control: tap selection, window counting and accumulator enable.
    always_comb begin
        tap_s     = tap_r;
        win_inc_s = 1'b0;
        win_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            FILL: begin
                win_clr_s = 1'b1;
            end
            SEARCH: begin
                win_inc_s = sample_s;
            end
            LOCKED: begin
                tap_s     = o_delay;
                win_inc_s = sample_s & RELOCK_ON;
                cnt_en_s  = sample_s;
            end
            default: begin
                win_clr_s = 1'b1;
            end
        endcase
    end

    // Reference history, sweep bookkeeping and all registered outputs.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr_r       <= '0;
            tap_r      <= '0;
            fill_r     <= '0;
            best_r     <= '1;
            best_tap_r <= '0;
            o_err      <= 1'b0;
            o_locked   <= 1'b0;
            o_delay    <= '0;
            o_best_err <= '0;
            o_bit_cnt  <= '0;
            o_err_cnt  <= '0;
            o_sweeps   <= '0;
            o_lol      <= 1'b0;
        end else begin
            if (sample_s) begin
                sr_r <= {sr_r[DEPTH-2:0], i_prbs};
            end
            if (i_enable) begin
                o_err <= i_valid & e_s;
            end
            o_lol    <= lol_s;
            o_locked <= (state_s == LOCKED);
            case (state_r)
                FILL: begin
                    if (fill_done_s) begin
                        fill_r <= '0;
                        tap_r  <= '0;
                        best_r <= '1;
                    end else if (sample_s) begin
                        fill_r <= fill_r + FW'(1);
                    end
                end
                SEARCH: begin
                    if (sweep_end_s) begin
                        tap_r <= '0;
                        if (lock_ok_s) begin
                            o_delay    <= best_tap_next_s;
                            o_best_err <= best_next_s;
                            best_r     <= best_next_s;
                            best_tap_r <= best_tap_next_s;
                        end else begin
                            best_r   <= '1;
                            o_sweeps <= SWEEP_W'(sat_add(SAT_W'(o_sweeps), 1'b1, SWEEP_W));
                        end
                    end else if (win_last_s) begin
                        best_r     <= best_next_s;
                        best_tap_r <= best_tap_next_s;
                        tap_r      <= tap_r + DW'(1);
                    end
                end
                LOCKED: begin
                    if (lol_s) begin
                        tap_r  <= '0;
                        best_r <= '1;
                        fill_r <= '0;
                    end
                end
                default: begin
                    tap_r <= '0;
                end
            endcase
            // Clear has priority over a same-cycle count.
            if (i_clear) begin
                o_bit_cnt <= '0;
                o_err_cnt <= '0;
            end else if (cnt_en_s) begin
                o_bit_cnt <= CNT_W'(sat_add(SAT_W'(o_bit_cnt), 1'b1, CNT_W));
                o_err_cnt <= CNT_W'(sat_add(SAT_W'(o_err_cnt), e_s, CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_ber_delay_checker.sv
// Directed bench for ber_delay_checker: table of lock/sweep vectors plus multi-cycle sequences.
module tb_ber_delay_checker;

    logic        clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_enable = 1'b0, i_valid = 1'b0, i_rx = 1'b0, i_prbs = 1'b0, i_clear = 1'b0;
    logic        o_err, o_locked, o_lol;
    logic [3:0]  o_delay;
    logic [4:0]  o_best_err;
    logic [63:0] o_bit_cnt, o_err_cnt;
    logic [7:0]  o_sweeps;

    ber_delay_checker #(
        .DEPTH(16), .WIN_LEN(31), .LOCK_THR(0), .RELOCK_THR(4), .CNT_W(64)
    ) dut (
        .clock(clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_valid(i_valid),
        .i_rx(i_rx), .i_prbs(i_prbs), .i_clear(i_clear), .o_err(o_err), .o_locked(o_locked),
        .o_delay(o_delay), .o_best_err(o_best_err), .o_bit_cnt(o_bit_cnt),
        .o_err_cnt(o_err_cnt), .o_sweeps(o_sweeps), .o_lol(o_lol)
    );

    always #5 clock = ~clock;

    typedef struct {
        int period;
        int delay;
        bit inv;
        bit gaps;
        int nsamp;
        bit exp_locked;
        int exp_delay;
        int exp_best;
        int exp_sweeps;
    } vec_t;

    vec_t        vecs[10];
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  lfsr = 7'h7F;
    logic [63:0] hist = 64'd0;
    int          delay_g = 6;
    bit          inv_g = 1'b0;
    bit          lol_seen = 1'b0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One valid sample: reference is PRBS7, received bit is the reference delayed by delay_g samples.
    task automatic do_sample(input bit flip, input bit clr);
        logic p;
        p         = lfsr[6] ^ lfsr[5];
        lfsr      = {lfsr[5:0], p};
        i_valid   = 1'b1;
        i_enable  = 1'b1;
        i_prbs    = p;
        i_rx      = hist[delay_g-1] ^ inv_g ^ flip;
        i_clear   = clr;
        @(posedge clock);
        #1;
        hist      = {hist[62:0], p};
        i_clear   = 1'b0;
        if (o_lol) lol_seen = 1'b1;
    endtask

    // A cycle the DUT must ignore: either no strobe, or strobe with enable low.
    task automatic idle(input bit en_low);
        i_valid  = en_low;
        i_enable = ~en_low;
        i_prbs   = 1'($urandom_range(0, 1));
        i_rx     = 1'($urandom_range(0, 1));
        i_clear  = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_enable  = 1'b0;
        i_clear   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        i_reset_n = 1'b1;
        lol_seen  = 1'b0;
    endtask

    task automatic run(input int period, input bit gaps, input int nsamp);
        int s;
        int cyc;
        s   = 0;
        cyc = 0;
        while (s < nsamp) begin
            if (gaps && (cyc % 5 == 4)) begin
                idle(1'b1);
            end else if ((period > 1) && (cyc % period != 0)) begin
                idle(1'b0);
            end else begin
                do_sample(1'b0, 1'b0);
                s++;
            end
            cyc++;
        end
    endtask

    initial begin
        vecs[0] = '{1, 6,  1'b0, 1'b0, 511,  1'b0, 0,  0, 0};
        vecs[1] = '{1, 6,  1'b0, 1'b0, 512,  1'b1, 5,  0, 0};
        vecs[2] = '{3, 6,  1'b0, 1'b0, 511,  1'b0, 0,  0, 0};
        vecs[3] = '{3, 6,  1'b0, 1'b0, 512,  1'b1, 5,  0, 0};
        vecs[4] = '{1, 1,  1'b0, 1'b0, 512,  1'b1, 0,  0, 0};
        vecs[5] = '{1, 16, 1'b0, 1'b0, 512,  1'b1, 15, 0, 0};
        vecs[6] = '{1, 6,  1'b0, 1'b1, 512,  1'b1, 5,  0, 0};
        vecs[7] = '{1, 6,  1'b1, 1'b0, 511,  1'b0, 0,  0, 0};
        vecs[8] = '{1, 6,  1'b1, 1'b0, 512,  1'b0, 0,  0, 1};
        vecs[9] = '{1, 6,  1'b1, 1'b0, 1008, 1'b0, 0,  0, 2};

        // Reset values while reset is held.
        #2;
        check("rst_locked", 64'(o_locked), 64'd0);
        check("rst_delay", 64'(o_delay), 64'd0);
        check("rst_best", 64'(o_best_err), 64'd0);
        check("rst_bits", o_bit_cnt, 64'd0);
        check("rst_errs", o_err_cnt, 64'd0);
        check("rst_sweeps", 64'(o_sweeps), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_lol", 64'(o_lol), 64'd0);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            delay_g = vecs[v].delay;
            inv_g   = vecs[v].inv;
            run(vecs[v].period, vecs[v].gaps, vecs[v].nsamp);
            check($sformatf("v%0d_locked", v), 64'(o_locked), 64'(vecs[v].exp_locked));
            check($sformatf("v%0d_delay", v), 64'(o_delay), 64'(vecs[v].exp_delay));
            check($sformatf("v%0d_best", v), 64'(o_best_err), 64'(vecs[v].exp_best));
            check($sformatf("v%0d_sweeps", v), 64'(o_sweeps), 64'(vecs[v].exp_sweeps));
            check($sformatf("v%0d_bits", v), o_bit_cnt, 64'd0);
        end

        // Sparse strobe after lock: only valid cycles are counted.
        do_reset();
        delay_g = 6;
        inv_g   = 1'b0;
        run(3, 1'b0, 512);
        run(3, 1'b0, 10);
        check("sparse_bits", o_bit_cnt, 64'd10);
        check("sparse_errs", o_err_cnt, 64'd0);

        // Locked error injection, then clear colliding with a counted error.
        do_reset();
        run(1, 1'b0, 512);
        check("inj_locked", 64'(o_locked), 64'd1);
        for (int i = 0; i < 1000; i++) begin
            do_sample((i % 100) == 99, 1'b0);
            if (i == 99)  check("inj_oerr_hi", 64'(o_err), 64'd1);
            if (i == 100) check("inj_oerr_lo", 64'(o_err), 64'd0);
        end
        check("inj_bits", o_bit_cnt, 64'd1000);
        check("inj_errs", o_err_cnt, 64'd10);
        check("inj_no_lol", 64'(lol_seen), 64'd0);
        do_sample(1'b1, 1'b1);
        check("clr_bits", o_bit_cnt, 64'd0);
        check("clr_errs", o_err_cnt, 64'd0);
        check("clr_locked", 64'(o_locked), 64'd1);
        do_sample(1'b0, 1'b0);
        check("post_clr_bits", o_bit_cnt, 64'd1);

        // Asynchronous reset mid-SEARCH (second sweep, tap 9), then a clean relock.
        do_reset();
        inv_g = 1'b1;
        run(1, 1'b0, 16 + 496 + 31 * 9 + 10);
        check("pre_rst_sweeps", 64'(o_sweeps), 64'd1);
        i_reset_n = 1'b0;
        #2;
        check("async_sweeps", 64'(o_sweeps), 64'd0);
        check("async_locked", 64'(o_locked), 64'd0);
        check("async_err", 64'(o_err), 64'd0);
        i_valid  = 1'b0;
        i_enable = 1'b0;
        @(posedge clock);
        #1;
        i_reset_n = 1'b1;
        inv_g     = 1'b0;
        run(1, 1'b0, 511);
        check("rerun_not_yet", 64'(o_locked), 64'd0);
        run(1, 1'b0, 1);
        check("rerun_locked", 64'(o_locked), 64'd1);
        check("rerun_delay", 64'(o_delay), 64'd5);

`ifdef BER_CHK_RELOCK_EN
        // Delay jump while locked: loss of lock at the first window end, then relock at tap 10.
        delay_g = 11;
        run(1, 1'b0, 30);
        check("lol_not_yet", 64'(lol_seen), 64'd0);
        run(1, 1'b0, 1);
        check("lol_pulse", 64'(o_lol), 64'd1);
        check("lol_unlocked", 64'(o_locked), 64'd0);
        check("lol_bits_held", o_bit_cnt, 64'd31);
        run(1, 1'b0, 1);
        check("lol_one_cycle", 64'(o_lol), 64'd0);
        run(1, 1'b0, 511);
        check("relock_locked", 64'(o_locked), 64'd1);
        check("relock_delay", 64'(o_delay), 64'd10);
        check("relock_bits_held", o_bit_cnt, 64'd31);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
